// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for the ALU, MEM (load) and EX (multiply)
// pipelines. Grants are combinational so the hazard unit can stall losers in
// the same cycle; the winning write is registered into the RF one cycle later.
// Per-source wait counters promote a repeatedly denied source to "urgent" so
// that no pipeline can be starved by the others.
module wb_port_arbiter #(
    parameter int REGISTER_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_WAIT       = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alu_wb_req_i,
    input  logic [REGISTER_WIDTH-1:0] alu_wb_reg_i,
    input  logic [DATA_WIDTH-1:0]     alu_wb_data_i,
    input  logic                      mem_wb_req_i,
    input  logic [REGISTER_WIDTH-1:0] mem_wb_reg_i,
    input  logic [DATA_WIDTH-1:0]     mem_wb_data_i,
    input  logic                      ex_wb_req_i,
    input  logic [REGISTER_WIDTH-1:0] ex_wb_reg_i,
    input  logic [DATA_WIDTH-1:0]     ex_wb_data_i,
    output logic                      alu_allowed_wb_o,
    output logic                      mem_allowed_wb_o,
    output logic                      ex_allowed_wb_o,
    output logic                      rf_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] rf_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     rf_wr_data_o
);

    // Source indices; a higher index wins ties within a priority class.
    localparam int NUM_SRC   = 3;
    localparam int SRC_ALU   = 0;
    localparam int SRC_MEM   = 1;
    localparam int SRC_EX    = 2;
    localparam int CNT_WIDTH = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);

    // Per-source request bundles gathered into arrays so the per-source logic
    // can be generated uniformly.
    logic [NUM_SRC-1:0]        req;
    logic [REGISTER_WIDTH-1:0] src_reg  [NUM_SRC];
    logic [DATA_WIDTH-1:0]     src_data [NUM_SRC];

    assign req[SRC_ALU]      = alu_wb_req_i;
    assign req[SRC_MEM]      = mem_wb_req_i;
    assign req[SRC_EX]       = ex_wb_req_i;
    assign src_reg[SRC_ALU]  = alu_wb_reg_i;
    assign src_reg[SRC_MEM]  = mem_wb_reg_i;
    assign src_reg[SRC_EX]   = ex_wb_reg_i;
    assign src_data[SRC_ALU] = alu_wb_data_i;
    assign src_data[SRC_MEM] = mem_wb_data_i;
    assign src_data[SRC_EX]  = ex_wb_data_i;

    // is_x0:     request to x0, granted for free, never touches the port
    // is_comp:   real write competing for the single port
    // is_urgent: competitor that has been denied MAX_WAIT cycles in a row
    logic [NUM_SRC-1:0] is_x0;
    logic [NUM_SRC-1:0] is_comp;
    logic [NUM_SRC-1:0] is_urgent;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] win;
    logic [NUM_SRC-1:0] grant;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [CNT_WIDTH-1:0] wait_cnt_reg;
            logic [CNT_WIDTH-1:0] wait_cnt_next;

            assign is_x0[gi]     = req[gi] && (src_reg[gi] == '0);
            assign is_comp[gi]   = req[gi] && (src_reg[gi] != '0);
            assign is_urgent[gi] = is_comp[gi] && (wait_cnt_reg == CNT_MAX);

            // Count consecutive denied cycles, saturating; any grant or idle cycle clears it.
            always_comb begin
                wait_cnt_next = '0;
                if (req[gi] && !grant[gi]) begin
                    if (wait_cnt_reg == CNT_MAX) begin
                        wait_cnt_next = wait_cnt_reg;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + CNT_WIDTH'(1);
                    end
                end
            end

            // Wait-counter state.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wait_cnt_reg <= '0;
                end else begin
                    wait_cnt_reg <= wait_cnt_next;
                end
            end
        end
    endgenerate

    // Pick one port winner: urgent class first, else all competitors; the
    // loop runs low to high so the highest-index candidate (EX) ends up winning.
    always_comb begin
        win  = '0;
        cand = (|is_urgent) ? is_urgent : is_comp;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
        end
    end

    assign grant = is_x0 | win;

    assign alu_allowed_wb_o = grant[SRC_ALU];
    assign mem_allowed_wb_o = grant[SRC_MEM];
    assign ex_allowed_wb_o  = grant[SRC_EX];

    // Select the winner's index/data; hold the previous values when idle.
    logic [REGISTER_WIDTH-1:0] wr_reg_reg,  wr_reg_next;
    logic [DATA_WIDTH-1:0]     wr_data_reg, wr_data_next;
    logic                      wr_en_reg;

    always_comb begin
        wr_reg_next  = wr_reg_reg;
        wr_data_next = wr_data_reg;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win[i]) begin
                wr_reg_next  = src_reg[i];
                wr_data_next = src_data[i];
            end
        end
    end

    // One-cycle write pipeline into the register file; reset drops any pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_reg   <= 1'b0;
            wr_reg_reg  <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg   <= |win;
            wr_reg_reg  <= wr_reg_next;
            wr_data_reg <= wr_data_next;
        end
    end

    assign rf_wr_en_o   = wr_en_reg;
    assign rf_wr_reg_o  = wr_reg_reg;
    assign rf_wr_data_o = wr_data_reg;

endmodule
